// File: rtl/bird_game_ctrl.sv
// Game-state controller for the bird game: collision detection against the
// pipe slot and ground, IDLE/PLAY/DEAD sequencing and best-score latch.
module bird_game_ctrl #(
  parameter int unsigned slot_width   = 60,
  parameter int unsigned slot_height  = 100,
  parameter int unsigned bird_HPos    = 320,
  parameter int unsigned bird_Xwidth  = 34,
  parameter int unsigned bird_Yheight = 24,
  parameter int unsigned ground_Y     = 436,
  parameter int unsigned dead_hold    = 500
) (
  input  logic       clk_2ms,
  input  logic       rst_n,
  input  logic       btn_jump,
  input  logic [8:0] bird_Y,
  input  logic [9:0] pip_X,
  input  logic [8:0] pip_Y,
  input  logic [7:0] score,
  output logic [1:0] state,
  output logic       collide,
  output logic [7:0] best_score
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  localparam int HOLD_W = $clog2(dead_hold + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(dead_hold);
  localparam logic [10:0] X_LO = 11'(bird_HPos - bird_Xwidth);
  localparam logic [10:0] X_HI = 11'(bird_HPos + slot_width);
  localparam logic [11:0] SLOT_H = 12'(slot_height);
  localparam logic [11:0] BIRD_H = 12'(bird_Yheight);
  localparam logic [11:0] GROUND = 12'(ground_Y);

  state_t              state_reg, state_next;
  logic                collide_reg, collide_next;
  logic [7:0]          best_reg, best_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next;
  logic                btn_prev_reg;

  logic                jump_rise;
  logic [10:0]         pip_x_ext;
  logic [11:0]         bird_y_ext, pip_y_ext;
  logic                h_overlap, v_safe, ground_hit, hit;

  assign jump_rise = btn_jump & ~btn_prev_reg;

  // Widened compares only; pip_Y - slot_height would underflow near the top.
  assign pip_x_ext  = {1'b0, pip_X};
  assign bird_y_ext = {3'b000, bird_Y};
  assign pip_y_ext  = {3'b000, pip_Y};
  assign h_overlap  = (pip_x_ext > X_LO) && (pip_x_ext < X_HI);
  assign v_safe     = ((bird_y_ext + SLOT_H) >= pip_y_ext) &&
                      ((bird_y_ext + BIRD_H) <= pip_y_ext);
  assign ground_hit = (bird_y_ext + BIRD_H) >= GROUND;
  assign hit        = ground_hit | (h_overlap & ~v_safe);

  always_ff @(posedge clk_2ms or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      collide_reg  <= 1'b0;
      best_reg     <= 8'd0;
      hold_reg     <= '0;
      btn_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      collide_reg  <= collide_next;
      best_reg     <= best_next;
      hold_reg     <= hold_next;
      btn_prev_reg <= btn_jump;
    end
  end

  always_comb begin
    state_next   = state_reg;
    collide_next = 1'b0;
    best_next    = best_reg;
    hold_next    = hold_reg;
    case (state_reg)
      S_IDLE: begin
        if (jump_rise) state_next = S_PLAY;
      end
      S_PLAY: begin
        if (hit) begin
          state_next   = S_DEAD;
          collide_next = 1'b1;
          hold_next    = '0;
          if (score > best_reg) best_next = score;
        end
      end
      S_DEAD: begin
        // Exit test uses the pre-increment count, so a press on the tick the
        // count saturates is still ignored.
        if (hold_reg != HOLD_MAX) hold_next = hold_reg + 1'b1;
        if (jump_rise && (hold_reg == HOLD_MAX)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign state      = state_reg;
  assign collide    = collide_reg;
  assign best_score = best_reg;

endmodule
